// File: rtl/seq_nibble_cmp.sv
// Sequential WIDTH-bit equality comparator: scans MSB-first one nibble per clock through bit_four_cmp.
// Optional macro SEQ_CMP_EARLY_EXIT_EN ends the scan on the first mismatching nibble.

module bit_four_cmp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq
);
  assign eq = (a == b);
endmodule

module seq_nibble_cmp #(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / 4,
  localparam int IW    = $clog2(NIB)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [IW-1:0]    mism_idx
);

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);
  localparam logic [IW-1:0] IDX_ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [IW-1:0]    idx_q, idx_d, pend_q, pend_d, mism_idx_q, mism_idx_d;
  logic             mism_q, mism_d, busy_q, busy_d, done_q, done_d, eq_q, eq_d;

  logic [WIDTH-1:0] ra_sh_s, rb_sh_s;
  logic             nib_eq_s, mism_now_s, last_s;
  logic [IW-1:0]    pend_now_s;

  // Current nibble pair selected by the scan cursor
  assign ra_sh_s = ra_q >> {idx_q, 2'b00};
  assign rb_sh_s = rb_q >> {idx_q, 2'b00};

  bit_four_cmp u_cmp (
    .a  (ra_sh_s[3:0]),
    .b  (rb_sh_s[3:0]),
    .eq (nib_eq_s)
  );

  // Mismatch accumulation and scan termination for the nibble under the cursor
  always_comb begin
    mism_now_s = mism_q | ~nib_eq_s;
    if (!mism_q && !nib_eq_s) begin
      pend_now_s = idx_q;
    end else begin
      pend_now_s = pend_q;
    end
`ifdef SEQ_CMP_EARLY_EXIT_EN
    last_s = (idx_q == IDX_ZERO) || !nib_eq_s;
`else
    last_s = (idx_q == IDX_ZERO);
`endif
  end

  // Next-state computation for the IDLE/SCAN controller
  always_comb begin
    state_d    = state_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    mism_d     = mism_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    eq_d       = eq_q;
    mism_idx_d = mism_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          idx_d   = IDX_LAST;
          pend_d  = IDX_ZERO;
          mism_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_SCAN: begin
        mism_d = mism_now_s;
        pend_d = pend_now_s;
        if (last_s) begin
          eq_d       = ~mism_now_s;
          mism_idx_d = mism_now_s ? pend_now_s : IDX_ZERO;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          idx_d      = idx_q - {{(IW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any scan without a done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ra_q       <= '0;
      rb_q       <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      mism_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      eq_q       <= 1'b0;
      mism_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      mism_q     <= mism_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      eq_q       <= eq_d;
      mism_idx_q <= mism_idx_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign eq       = eq_q;
  assign mism_idx = mism_idx_q;

endmodule

// File: tb/tb_seq_nibble_cmp.sv
// Directed self-checking bench for seq_nibble_cmp (WIDTH=16), honouring SEQ_CMP_EARLY_EXIT_EN if defined.

module tb_seq_nibble_cmp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        busy, done, eq;
  logic [1:0]  mism_idx;

  int checks = 0;
  int errors = 0;
  logic       prev_eq  = 1'b0;
  logic [1:0] prev_idx = 2'd0;

`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  seq_nibble_cmp #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .eq       (eq),
    .mism_idx (mism_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [15:0] va;
    logic [15:0] vb;
    logic       exp_eq;
    logic [1:0] exp_idx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic e, input logic [1:0] k);
    if (EARLY && !e) return 4 - int'(k);
    return 4;
  endfunction

  // Waits for done after an accepted start at the most recent edge; returns edges counted
  task automatic wait_done(input string name, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n = i;
        break;
      end
      chk({name, "_eq_hold"}, {31'd0, eq}, {31'd0, prev_eq});
      chk({name, "_idx_hold"}, {30'd0, mism_idx}, {30'd0, prev_idx});
      chk({name, "_busy_mid"}, {31'd0, busy}, 32'd1);
    end
    if (n == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_cmp(input string name, input logic [15:0] va, input logic [15:0] vb,
                         input logic e, input logic [1:0] k);
    int n;
    @(negedge clk);
    start = 1'b1; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0; a = ~va; b = ~vb;
    chk({name, "_busy_e0"}, {31'd0, busy}, 32'd1);
    chk({name, "_done_e0"}, {31'd0, done}, 32'd0);
    wait_done(name, n);
    chk({name, "_lat"}, n, exp_lat(e, k));
    chk({name, "_eq"}, {31'd0, eq}, {31'd0, e});
    chk({name, "_idx"}, {30'd0, mism_idx}, {30'd0, k});
    chk({name, "_busy_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    prev_eq = e; prev_idx = k;
  endtask

  task automatic reset_mid(input string name);
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1; #1;
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
    chk({name, "_eq"}, {31'd0, eq}, 32'd0);
    chk({name, "_idx"}, {30'd0, mism_idx}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk({name, "_no_done"}, {31'd0, done}, 32'd0);
    end
    @(negedge clk); reset = 1'b0;
    prev_eq = 1'b0; prev_idx = 2'd0;
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{"equal",     16'hA5C3, 16'hA5C3, 1'b1, 2'd0};
    vecs[1] = '{"msb_mism",  16'h1234, 16'h9234, 1'b0, 2'd3};
    vecs[2] = '{"lsb_mism",  16'h1234, 16'h1235, 1'b0, 2'd0};
    vecs[3] = '{"nib2_mism", 16'h1F34, 16'h1034, 1'b0, 2'd2};
    vecs[4] = '{"nib1_mism", 16'h12F4, 16'h1204, 1'b0, 2'd1};
    vecs[5] = '{"zero_eq",   16'h0000, 16'h0000, 1'b1, 2'd0};
    vecs[6] = '{"all_mism",  16'hFFFF, 16'h0000, 1'b0, 2'd3};
    vecs[7] = '{"ends_mism", 16'h8001, 16'h0001, 1'b0, 2'd3};

    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_eq",   {31'd0, eq},   32'd0);
    chk("rst_idx",  {30'd0, mism_idx}, 32'd0);
    @(negedge clk); @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_cmp(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].exp_eq, vecs[i].exp_idx);

    // Start while busy: second request must be ignored
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h1234;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b1; a = 16'h0000; b = 16'hFFFF;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    for (int i = 3; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin n = i; break; end
    end
    chk("busy_start_lat", n, 4);
    chk("busy_start_eq", {31'd0, eq}, 32'd1);
    chk("busy_start_idx", {30'd0, mism_idx}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("busy_start_one_done", {31'd0, done}, 32'd0);
      chk("busy_start_idle", {31'd0, busy}, 32'd0);
    end
    prev_eq = 1'b1; prev_idx = 2'd0;

    // Back-to-back: start held high across the done cycle
    @(negedge clk);
    start = 1'b1; a = 16'hA5C3; b = 16'hA5C3;
    @(posedge clk); #1;
    wait_done("b2b_first", n);
    chk("b2b_first_lat", n, 4);
    chk("b2b_first_eq", {31'd0, eq}, 32'd1);
    a = 16'h1234; b = 16'h1235;
    @(posedge clk); #1;
    start = 1'b0; a = 16'h0000; b = 16'h0000;
    chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
    chk("b2b_accept_done", {31'd0, done}, 32'd0);
    chk("b2b_accept_eq_hold", {31'd0, eq}, 32'd1);
    wait_done("b2b_second", n);
    chk("b2b_second_lat", n, 4);
    chk("b2b_second_eq", {31'd0, eq}, 32'd0);
    chk("b2b_second_idx", {30'd0, mism_idx}, 32'd0);
    prev_eq = 1'b0; prev_idx = 2'd0;

    // Reset mid-scan after results that differ from the reset values
    run_cmp("pre_rst_a", 16'h1F34, 16'h1034, 1'b0, 2'd2);
    reset_mid("rst_mid_a");
    run_cmp("post_rst_a", 16'h5555, 16'h5555, 1'b1, 2'd0);
    reset_mid("rst_mid_b");
    run_cmp("post_rst_b", 16'h1234, 16'h9234, 1'b0, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
